fetch_aligner: RTL

- Sits between instruction memory fetch and the decode stage.
- Buffers fixed-width fetch words as 16-bit parcels in a circular queue and re-aligns them into whole instructions.
- Supports RVC: 16-bit instructions, and 32-bit instructions that straddle fetch-word boundaries.
- Tracks the PC of each emitted instruction; handles redirect/flush to a halfword-aligned target.

---
 rtl/core_pkg.sv | 16 +
 rtl/parcel_queue.sv | 66 ++++++
 rtl/fetch_aligner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared front-end types: 16-bit instruction parcels, opcode field type and the
// RVC length decode used by the fetch aligner.
package core_pkg;

    typedef logic [15:0] parcel_t;
    typedef logic [6:0]  opcode_t;

    localparam logic [1:0] RVC_QUADRANT_32 = 2'b11;
    localparam opcode_t    OPCODE_NONE     = 7'h00;

    // A parcel starts a 16-bit instruction unless its low two bits select quadrant 3.
    function automatic logic is_compressed(input parcel_t p);
        return (p[1:0] != RVC_QUADRANT_32);
    endfunction

endpackage

// File: rtl/parcel_queue.sv
// Circular buffer of 16-bit parcels: up to W parcels written per cycle, a
// two-parcel read window at the head, and a registered occupancy count.
module parcel_queue
    import core_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int W     = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear,
    input  logic [CW-1:0]   push_n,
    input  logic [W*16-1:0] push_data,
    input  logic [1:0]      pop_n,
    output logic [CW-1:0]   count,
    output parcel_t         head0,
    output parcel_t         head1
);

    parcel_t       mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] widx_s [W];
    logic [PW-1:0] rd_next_s;

    // Slot for each incoming parcel; modulo-DEPTH wrap falls out of the PW-bit truncation.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            widx_s[i] = wr_ptr_r + PW'(i);
        end
        rd_next_s = rd_ptr_r + PW'(1);
    end

    // Parcel storage, pointers and occupancy; clear restarts an empty queue at slot 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (CW'(i) < push_n) begin
                    mem_r[widx_s[i]] <= push_data[i*16 +: 16];
                end
            end
            wr_ptr_r <= wr_ptr_r + push_n[PW-1:0];
            rd_ptr_r <= rd_ptr_r + PW'(pop_n);
            count_r  <= count_r + push_n - CW'(pop_n);
        end
    end

    assign count = count_r;
    assign head0 = mem_r[rd_ptr_r];
    assign head1 = mem_r[rd_next_s];

endmodule

// File: rtl/fetch_aligner.sv
// Re-aligns fetch words into whole RV instructions (16- or 32-bit), tracking the
// PC of the instruction at the head and handling redirects to halfword targets.
module fetch_aligner
    import core_pkg::*;
#(
    parameter int FETCH_WIDTH = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int PC_WIDTH    = 64,
    parameter bit RVC_EN      = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush_i,
    input  logic [PC_WIDTH-1:0]    flush_pc_i,
    input  logic                   fetch_valid_i,
    output logic                   fetch_ready_o,
    input  logic [FETCH_WIDTH-1:0] fetch_data_i,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output logic [31:0]            inst_o,
    output logic [PC_WIDTH-1:0]    inst_pc_o,
    output logic                   inst_compressed_o,
    output opcode_t                inst_opcode_o
);

    localparam int            W           = FETCH_WIDTH / 16;
    localparam int            PW          = $clog2(QUEUE_DEPTH);
    localparam int            CW          = PW + 1;
    localparam logic [CW-1:0] READY_LIMIT = CW'(QUEUE_DEPTH - W);

    logic [PC_WIDTH-1:0]    head_pc_r;
    logic                   skip_r;
    logic [CW-1:0]          count_s;
    logic [CW-1:0]          push_n_s;
    logic [1:0]             pop_n_s;
    logic [FETCH_WIDTH-1:0] push_data_s;
    parcel_t                head0_s;
    parcel_t                head1_s;
    logic                   compressed_s;
    logic                   valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   unused_s;

    assign unused_s = flush_pc_i[0];

    // Length decode of the head parcel and both handshakes; only registered count gates fetch.
    always_comb begin
        compressed_s  = RVC_EN && is_compressed(head0_s);
        if (compressed_s) begin
            valid_s = (count_s >= CW'(1));
        end else begin
            valid_s = (count_s >= CW'(2));
        end
        fetch_ready_o = (count_s <= READY_LIMIT) && !flush_i;
        push_s        = fetch_valid_i && fetch_ready_o;
        pop_s         = valid_s && inst_ready_i && !flush_i;

        if (!push_s) begin
            push_n_s = '0;
        end else if (skip_r) begin
            push_n_s = CW'(W - 1);
        end else begin
            push_n_s = CW'(W);
        end

        // After a redirect to PC[1]=1 the low parcel of the first word is not ours.
        if (skip_r) begin
            push_data_s = {16'h0000, fetch_data_i[FETCH_WIDTH-1:16]};
        end else begin
            push_data_s = fetch_data_i;
        end

        if (!pop_s) begin
            pop_n_s = 2'd0;
        end else if (compressed_s) begin
            pop_n_s = 2'd1;
        end else begin
            pop_n_s = 2'd2;
        end
    end

    // Instruction outputs, forced to zero whenever nothing complete sits at the head.
    always_comb begin
        inst_valid_o      = valid_s;
        inst_pc_o         = head_pc_r;
        inst_compressed_o = valid_s && compressed_s;
        if (valid_s && compressed_s) begin
            inst_o        = {16'h0000, head0_s};
            inst_opcode_o = OPCODE_NONE;
        end else if (valid_s) begin
            inst_o        = {head1_s, head0_s};
            inst_opcode_o = head0_s[6:0];
        end else begin
            inst_o        = 32'h0000_0000;
            inst_opcode_o = OPCODE_NONE;
        end
    end

    // Head PC and the drop-first-parcel flag; a flush overrides any pop or push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_pc_r <= '0;
            skip_r    <= 1'b0;
        end else if (flush_i) begin
            head_pc_r <= {flush_pc_i[PC_WIDTH-1:2], flush_pc_i[1] & RVC_EN, 1'b0};
            skip_r    <= flush_pc_i[1] & RVC_EN;
        end else begin
            if (pop_s) begin
                head_pc_r <= head_pc_r + (compressed_s ? PC_WIDTH'(2) : PC_WIDTH'(4));
            end else begin
                head_pc_r <= head_pc_r;
            end
            if (push_s) begin
                skip_r <= 1'b0;
            end else begin
                skip_r <= skip_r;
            end
        end
    end

    parcel_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (W)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (flush_i),
        .push_n    (push_n_s),
        .push_data (push_data_s),
        .pop_n     (pop_n_s),
        .count     (count_s),
        .head0     (head0_s),
        .head1     (head1_s)
    );

endmodule
